spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16, giving the transfer length width in bytes.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum cycles between work and busy rising.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  per-requester transaction request, bit i = requester i, held until done[i].
REQ-006 len0 / len1  input  LEN_W each  byte count for requester 0 / 1, stable while req[i]=1.
REQ-007 op  input  2  per-requester direction, bit i: 1 = write, 0 = read.
REQ-008 gnt  output  2  one-hot ownership of the SPI engine; bit i = requester i.
REQ-009 done  output  2  one-cycle completion pulse to requester i.
REQ-010 err  output  1  asserted only in the same cycle as a done pulse; marks a failed transaction.
REQ-011 sel  output  1  index of the current or last owner, driving the external FIFO data mux.
REQ-012 work  output  1  one-cycle start strobe to the SPI engine.
REQ-013 len  output  LEN_W  latched byte count presented to the SPI engine.
REQ-014 op_o  output  1  latched direction presented to the SPI engine.
REQ-015 busy  input  1  SPI engine activity flag.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT_BUSY, RUN, DONE, encoded in a registered FSM.
REQ-017 In IDLE with any req bit set, the block SHALL grant one requester in the next cycle:
- single requester: that one;
- both requesting: the requester not granted last (round-robin pointer last).
REQ-018 On grant, gnt, sel, len and op_o SHALL be latched from the winner and held constant until DONE completes.
REQ-019 A granted request with len = 0 SHALL skip ISSUE, go directly to DONE with err=1, and never assert work.
REQ-020 ISSUE SHALL last exactly one cycle with work=1, then go to WAIT_BUSY; work=0 in every other state.
REQ-021 WAIT_BUSY: when busy=1, the block SHALL go to RUN.
REQ-022 WAIT_BUSY: a LEN_W-independent 32-bit counter SHALL count cycles; on reaching TIMEOUT with busy=0, the block SHALL go to DONE with err=1.
REQ-023 RUN: when busy=0, the block SHALL go to DONE with err=0.
REQ-024 DONE SHALL last one cycle: done[sel]=1, err as determined; gnt cleared at the end of the cycle; last updated to sel; next state IDLE.
REQ-025 Latency: grant to work = 1 cycle; busy falling to done = 1 cycle.
REQ-026 Back-to-back operation: a request still asserted in the cycle after DONE SHALL be eligible for arbitration in that IDLE cycle (minimum one IDLE cycle between transactions).
REQ-027 Withdrawal of req[i] while granted SHALL be ignored; the transaction SHALL run to DONE.
REQ-028 busy=1 while in IDLE SHALL be ignored and SHALL NOT cause a grant.
REQ-029 The block SHALL assert at most one gnt bit and at most one done bit in any cycle.

Reset
REQ-030 While rst=1, regardless of the clock, the block SHALL force:
- state=IDLE, gnt=0, done=0, err=0, work=0, len=0, op_o=0, sel=0;
- counter=0, last=1, so requester 0 wins the first tie.
REQ-031 Reset mid-transaction SHALL abandon the transaction without a done pulse; after release, the block SHALL arbitrate afresh.

Verification
REQ-032 Single request: req=01, len0=4, op[0]=1; busy rises 2 cycles after work and stays high 10 cycles -> gnt=01, one work pulse, len=4, op_o=1, done=01 with err=0 one cycle after busy falls.
REQ-033 Tie: req=11 from reset, requesters re-request after done -> grant order 0,1,0,1, with sel matching each grant.
REQ-034 Zero length: req=10, len1=0 -> gnt=10, no work, done=10 with err=1 within 2 cycles of req.
REQ-035 Timeout: req=01, busy held 0 -> done=01 with err=1 exactly TIMEOUT cycles after entering WAIT_BUSY; the next request is served normally.
REQ-036 Reset in RUN: rst pulsed while busy=1 -> all outputs 0 immediately, no done pulse, and req=01 is then granted within 1 cycle of rst release.
REQ-037 Withdraw: req[0] dropped in WAIT_BUSY -> transaction completes and done[0] still pulses; busy=1 in IDLE with req=00 -> no grant.

Source files
------------

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: bundle between the two requesters, the SPI engine and
// spi_arbiter.
//   req[1:0]     per-requester request, held until the matching done bit
//   len0, len1   byte count for requester 0 / 1
//   op[1:0]      per-requester direction (1 = write, 0 = read)
//   busy         SPI engine activity flag
//   gnt[1:0]     one-hot ownership of the SPI engine
//   done[1:0]    one-cycle completion pulse per requester
//   err          failure flag, only valid alongside a done pulse
//   sel          index of current or last owner (external FIFO mux)
//   work         one-cycle start strobe to the SPI engine
//   len, op_o    latched byte count and direction for the SPI engine
// The slave modport is the arbiter's view; master is the environment's view.
interface spi_arbiter_if #(
  parameter int LEN_W = 16
);
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       op;
  logic             busy;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             err;
  logic             sel;
  logic             work;
  logic [LEN_W-1:0] len;
  logic             op_o;

  modport slave (
    input  req, len0, len1, op, busy,
    output gnt, done, err, sel, work, len, op_o
  );

  modport master (
    output req, len0, len1, op, busy,
    input  gnt, done, err, sel, work, len, op_o
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin arbiter in front of a single SPI
// engine. One transaction at a time: grant, one work strobe, wait for the
// engine to go busy (with timeout), wait for it to go idle, then a one-cycle
// done pulse to the owner.
// Ports:
//   clk  system clock, all state changes on its rising edge
//   rst  asynchronous active-high reset
//   bus  spi_arbiter_if.slave (requests, engine handshake, grant/done)
// Parameters:
//   LEN_W    width of the byte counts
//   TIMEOUT  maximum cycles spent waiting for busy to rise
module spi_arbiter #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  spi_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             winner;
  logic [LEN_W-1:0] winLen;

  // Arbitration: a lone requester wins outright; on a tie the requester
  // that did not own the engine last time wins.
  always_comb begin
    winner = bus.req[1];
    if (bus.req == 2'b11) begin
      winner = ~last_q;
    end
    winLen = winner ? bus.len1 : bus.len0;
  end

  // State and latched transaction registers. last resets to 1 so that
  // requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      sel_q   <= 1'b0;
      len_q   <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      op_q    <= op_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. req is only looked at in IDLE, so a requester
  // withdrawing mid-transaction has no effect, and busy is only looked at
  // while a transaction is in flight.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    len_d   = len_q;
    op_d    = op_q;
    err_d   = err_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d = winner ? 2'b10 : 2'b01;
          sel_d = winner;
          len_d = winLen;
          op_d  = bus.op[winner];
          // A zero-length transfer never reaches the engine.
          if (winLen == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = 32'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // The cycle counter includes the current cycle, so DONE lands
        // exactly TIMEOUT cycles after WAIT_BUSY was entered.
        if (bus.busy) begin
          state_d = RUN;
        end else if (cnt_q + 32'd1 >= 32'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (!bus.busy) begin
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = 2'b00;
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the state register so that reset clears them
  // immediately.
  assign bus.work = (state_q == ISSUE);
  assign bus.done = (state_q == DONE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.err  = (state_q == DONE) && err_q;
  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.len  = len_q;
  assign bus.op_o = op_q;

endmodule
